// File: rtl/led_fader_pkg.sv
// rtl/led_fader_pkg.sv - shared constants and step helpers for the LED PWM fader
//
// Purpose: default brightness width plus the level arithmetic shared by the
//          fader top and its per-LED channels.
// Contents:
//   DEFAULT_LEVEL_W - default brightness level width
//   lvl_max(w)      - full-on level for a w-bit brightness value
//   step_toward()   - one saturating +/-1 step of a level toward its target
package led_fader_pkg;

  localparam int DEFAULT_LEVEL_W = 4;

  function automatic int lvl_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Targets are always 0 or the full-on level, so stepping toward the target
  // can never leave the range [0, lvl_max]: saturation falls out naturally.
  function automatic int step_toward(input int level, input int target);
    if (level < target) begin
      return level + 1;
    end else if (level > target) begin
      return level - 1;
    end else begin
      return level;
    end
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one LED brightness ramp and PWM compare
//
// Purpose: holds one LED's brightness level, steps it toward the commanded
//          target on each ramp tick and produces the registered PWM drive.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   enable    in   0 blanks led_out on the next edge
//   ramp_tick in   single-cycle pulse: move level one step toward target
//   pwm_cnt   in   shared PWM counter
//   cmd       in   1 = target full-on, 0 = target off
//   led_out   out  registered PWM drive
//   busy      out  registered, 1 while level differs from target
module led_pwm_channel
  import led_fader_pkg::*;
#(
  parameter int LEVEL_W = DEFAULT_LEVEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               ramp_tick,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  input  logic               cmd,
  output logic               led_out,
  output logic               busy
);

  localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(lvl_max(LEVEL_W));

  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_next;
  logic [LEVEL_W-1:0] target;
  logic               pwm_on;

  always_comb begin
    target     = cmd ? LVL_MAX : '0;
    level_next = level_q;
    // The live command is used, so a change landing on the tick cycle counts.
    if (ramp_tick) begin
      level_next = LEVEL_W'(step_toward(int'(level_q), int'(target)));
    end
    // Full level forces constant on; otherwise 'level' ticks high per period.
    pwm_on = (level_q == LVL_MAX) || (pwm_cnt < level_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      led_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      level_q <= level_next;
      led_out <= enable && pwm_on;
      busy    <= (level_q != target);
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// rtl/led_pwm_fader.sv - PWM dimming and linear fades for the red board LEDs
//
// Purpose: turns the on/off LED PIO word into per-LED linear fades with PWM
//          output. A shared timebase (prescaler, PWM counter, ramp counter)
//          drives one led_pwm_channel per LED.
// Ports:
//   clk_clk     in   system clock, rising edge
//   reset_reset in   asynchronous active-high reset
//   led_cmd     in   per-LED target, 1 = on, 0 = off
//   enable      in   0 freezes the timebase and levels and blanks led_out
//   led_out     out  registered PWM drive to the pins
//   busy        out  registered, bit i = 1 while level[i] differs from target
module led_pwm_fader
  import led_fader_pkg::*;
#(
  parameter int NUM_LEDS     = 10,
  parameter int LEVEL_W      = DEFAULT_LEVEL_W,
  parameter int PRESCALE     = 256,
  parameter int RAMP_PERIODS = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_LEDS-1:0] led_cmd,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [NUM_LEDS-1:0] busy
);

  // Counters that only ever hold 0 still need one bit of storage.
  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int RAMP_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_PERIODS - 1);
  localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(lvl_max(LEVEL_W));

  logic [PRE_W-1:0]   pre_cnt;
  logic [LEVEL_W-1:0] pwm_cnt;
  logic [RAMP_W-1:0]  ramp_cnt;
  logic               pre_tc;
  logic               per_end;
  logic               ramp_tick;

  assign pre_tc  = (pre_cnt == PRE_LAST);
  assign per_end = pre_tc && (pwm_cnt == LVL_MAX);
  // Gated by enable so levels hold while the block is frozen.
  assign ramp_tick = enable && per_end && (ramp_cnt == RAMP_LAST);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= pre_tc ? '0 : pre_cnt + PRE_W'(1);
      if (pre_tc) begin
        // Natural LEVEL_W-bit overflow gives the LVL_MAX -> 0 wrap.
        pwm_cnt <= pwm_cnt + LEVEL_W'(1);
      end
      if (per_end) begin
        ramp_cnt <= (ramp_cnt == RAMP_LAST) ? '0 : ramp_cnt + RAMP_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : gen_ch
    led_pwm_channel #(
      .LEVEL_W(LEVEL_W)
    ) u_ch (
      .clk      (clk_clk),
      .rst      (reset_reset),
      .enable   (enable),
      .ramp_tick(ramp_tick),
      .pwm_cnt  (pwm_cnt),
      .cmd      (led_cmd[i]),
      .led_out  (led_out[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb/tb_led_pwm_fader.sv - self-checking bench for led_pwm_fader
module tb_led_pwm_fader;

  localparam int N    = 10;
  localparam int P    = 2;
  localparam int LW   = 2;
  localparam int R    = 1;
  localparam int LMAX = (1 << LW) - 1;
  localparam int PER  = P * (1 << LW);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] led_cmd = '0;
  logic         enable = 1'b0;
  logic [N-1:0] led_out;
  logic [N-1:0] busy;

  int checks = 0;
  int failures = 0;

  led_pwm_fader #(
    .NUM_LEDS(N),
    .LEVEL_W(LW),
    .PRESCALE(P),
    .RAMP_PERIODS(R)
  ) u_dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .led_cmd    (led_cmd),
    .enable     (enable),
    .led_out    (led_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: time is counted in enabled cycles; the PWM phase and the
  // step instants are derived from that count arithmetically.
  int           m_en_cyc = 0;
  int           m_level[N];
  logic [N-1:0] m_led = '0;
  logic [N-1:0] m_busy = '0;
  int           m_cnt;
  int           m_tgt;
  bit           m_tick;

  initial foreach (m_level[i]) m_level[i] = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_en_cyc = 0;
      foreach (m_level[i]) m_level[i] = 0;
      m_led  = '0;
      m_busy = '0;
    end else begin
      m_cnt  = (m_en_cyc / P) % (LMAX + 1);
      m_tick = enable && (m_en_cyc % PER == PER - 1) && ((m_en_cyc / PER) % R == R - 1);
      for (int i = 0; i < N; i++) begin
        m_tgt     = led_cmd[i] ? LMAX : 0;
        m_led[i]  = enable && (m_level[i] == LMAX || m_cnt < m_level[i]);
        m_busy[i] = (m_level[i] != m_tgt);
        if (m_tick) begin
          if (m_level[i] < m_tgt) m_level[i] = m_level[i] + 1;
          else if (m_level[i] > m_tgt) m_level[i] = m_level[i] - 1;
        end
      end
      if (enable) m_en_cyc = m_en_cyc + 1;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    led_cmd = '0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (led_out !== '0) begin
      failures++;
      $display("FAIL reset_led_out got=%h want=%h", led_out, {N{1'b0}});
    end
    checks++;
    if (busy !== '0) begin
      failures++;
      $display("FAIL reset_busy got=%h want=%h", busy, {N{1'b0}});
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    led_cmd = '0;
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (led_out !== '0 || busy !== '0) begin
        failures++;
        $display("FAIL idle cycle=%0d led_out=%h busy=%h want 0 0", c, led_out, busy);
      end
    end
  endtask

  task automatic test_rise();
    int want_duty[3] = '{2, 4, 8};
    int hi;
    int k;
    led_cmd = 10'h001;
    for (int s = 0; s < 3; s++) begin
      k = 0;
      while (m_level[0] != s + 1 && k < 60) begin
        @(negedge clk);
        k++;
        checks++;
        if (led_out !== m_led || busy !== m_busy) begin
          failures++;
          $display("FAIL rise_cycle led_out=%h busy=%h want %h %h", led_out, busy, m_led, m_busy);
        end
      end
      checks++;
      if (m_level[0] != s + 1) begin
        failures++;
        $display("FAIL rise_timeout step=%0d level=%0d want %0d", s, m_level[0], s + 1);
      end
      hi = 0;
      for (int c = 0; c < PER; c++) begin
        @(negedge clk);
        if (led_out[0]) hi++;
      end
      checks++;
      if (hi != want_duty[s]) begin
        failures++;
        $display("FAIL rise_duty step=%0d got=%0d want=%0d", s, hi, want_duty[s]);
      end
    end
    checks++;
    if (busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL rise_busy_clear got=%b want=0", busy[0]);
    end
  endtask

  task automatic test_fall();
    int want_lvl[3]  = '{2, 1, 0};
    int want_duty[3] = '{4, 2, 0};
    int hi;
    int k;
    led_cmd = '0;
    for (int s = 0; s < 3; s++) begin
      k = 0;
      while (m_level[0] != want_lvl[s] && k < 60) begin
        @(negedge clk);
        k++;
        checks++;
        if (led_out !== m_led || busy !== m_busy) begin
          failures++;
          $display("FAIL fall_cycle led_out=%h busy=%h want %h %h", led_out, busy, m_led, m_busy);
        end
      end
      hi = 0;
      for (int c = 0; c < PER; c++) begin
        @(negedge clk);
        if (led_out[0]) hi++;
      end
      checks++;
      if (hi != want_duty[s]) begin
        failures++;
        $display("FAIL fall_duty step=%0d got=%0d want=%0d", s, hi, want_duty[s]);
      end
    end
  endtask

  task automatic test_reversal();
    int hi;
    int k;
    led_cmd = 10'h001;
    k = 0;
    while (m_level[0] != 2 && k < 60) begin
      @(negedge clk);
      k++;
    end
    led_cmd = '0;
    k = 0;
    while (m_level[0] == 2 && k < 60) begin
      @(negedge clk);
      k++;
      checks++;
      if (led_out !== m_led || busy !== m_busy) begin
        failures++;
        $display("FAIL rev_cycle led_out=%h busy=%h want %h %h", led_out, busy, m_led, m_busy);
      end
    end
    hi = 0;
    for (int c = 0; c < PER; c++) begin
      @(negedge clk);
      if (led_out[0]) hi++;
    end
    // Level 1 after the reversal gives 2 high cycles; an overshoot to 3 gives 8.
    checks++;
    if (hi != 2) begin
      failures++;
      $display("FAIL rev_duty got=%0d want=2", hi);
    end
  endtask

  task automatic test_enable();
    int k;
    led_cmd = '0;
    k = 0;
    while (m_level[0] != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    led_cmd = 10'h001;
    k = 0;
    while (m_level[0] != 1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (led_out !== '0) begin
      failures++;
      $display("FAIL enable_blank got=%h want=0", led_out);
    end
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      checks++;
      if (led_out !== '0 || busy !== m_busy) begin
        failures++;
        $display("FAIL enable_hold led_out=%h busy=%h want 0 %h", led_out, busy, m_busy);
      end
    end
    enable = 1'b1;
    k = 0;
    while (m_level[0] != LMAX && k < 80) begin
      @(negedge clk);
      k++;
      checks++;
      if (led_out !== m_led || busy !== m_busy) begin
        failures++;
        $display("FAIL enable_resume led_out=%h busy=%h want %h %h", led_out, busy, m_led, m_busy);
      end
    end
    checks++;
    if (m_level[0] != LMAX) begin
      failures++;
      $display("FAIL enable_timeout level=%0d want=%0d", m_level[0], LMAX);
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 5) == 0) led_cmd = N'($urandom);
      if ($urandom_range(0, 9) == 0) enable = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (led_out !== m_led || busy !== m_busy) begin
        failures++;
        $display("FAIL random cycle=%0d led_out=%h busy=%h want %h %h", c, led_out, busy, m_led, m_busy);
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_async_reset();
    int hi;
    int k;
    enable = 1'b1;
    led_cmd = '0;
    k = 0;
    while (m_level[0] != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    led_cmd = '1;
    k = 0;
    while (m_level[0] != 2 && k < 60) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (led_out !== '0 || busy !== '0) begin
      failures++;
      $display("FAIL async_reset led_out=%h busy=%h want 0 0", led_out, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    led_cmd = 10'h001;
    k = 0;
    while (m_level[0] != 1 && k < 60) begin
      @(negedge clk);
      k++;
      checks++;
      if (led_out !== m_led || busy !== m_busy) begin
        failures++;
        $display("FAIL post_reset_cycle led_out=%h busy=%h want %h %h", led_out, busy, m_led, m_busy);
      end
    end
    hi = 0;
    for (int c = 0; c < PER; c++) begin
      @(negedge clk);
      if (led_out[0]) hi++;
    end
    checks++;
    if (hi != 2) begin
      failures++;
      $display("FAIL post_reset_duty got=%0d want=2", hi);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_rise();
    test_fall();
    test_reversal();
    test_enable();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
